uart_frame_rx: RTL and testbench
================================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on rx_line (legal 2..4).
REQ-002 clk  input  1  single receiver clock; every flop in the block is clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rx_line  input  1  serial line, asynchronous to clk, idle high.
REQ-005 clks_per_bit  input  10  bit period minus one, in clk cycles (bit period P = clks_per_bit+1); legal range 3..1023.
REQ-006 out_data  output  8  last received byte.
REQ-007 out_valid  output  1  out_data and flags are valid; held until accepted.
REQ-008 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-009 parity_err  output  1  received parity bit differs from ^out_data; valid only while out_valid is high.
REQ-010 frame_err  output  1  stop bit sampled low; valid only while out_valid is high.
REQ-011 overrun  output  1  the frame replaced an unaccepted byte; valid only while out_valid is high.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx_line shall pass through SYNC_STAGES flops, reset to 1; all decoding uses the synchronized value rx_s.
REQ-014 The FSM states shall be IDLE, START, DATA, PARITY, STOP.
REQ-015 The frame format is: start(0), 8 data bits LSB first, even parity (=^data), stop(1).
REQ-016 In IDLE, rx_s high-to-low (previous 1, current 0) shall enter START with bit counter cnt=0.
REQ-017 In START, at cnt == clks_per_bit>>1: if rx_s=0, go to DATA with cnt=0 and bit index 0; otherwise return to IDLE (glitch rejected, no output).
REQ-018 In DATA, PARITY and STOP, cnt counts 0..clks_per_bit; the sample is taken at cnt == clks_per_bit, then cnt wraps to 0.
REQ-019 DATA shall shift the sample in LSB first; after the 8th sample go to PARITY.
REQ-020 PARITY shall capture the parity bit and then go to STOP.
REQ-021 STOP sample cycle: out_data <= shift register; parity_err <= captured parity != ^shift; frame_err <= ~rx_s; overrun <= out_valid && !out_ready; out_valid <= 1; go to IDLE. Frame-error frames are still delivered.
REQ-022 Latency: out_valid shall be high in the cycle after the stop-bit sample edge.
REQ-023 When out_valid && out_ready, out_valid shall drop next cycle, unless a STOP sample occurs in the same cycle; in that case the new byte is loaded, out_valid stays 1, and overrun = 0.
REQ-024 Sampling at mid-stop means IDLE is re-entered half a bit early; a start edge arriving then shall be accepted.
REQ-025 clks_per_bit shall be changed only while busy = 0; mid-frame changes give undefined timing but the FSM shall not lock up.

Reset
REQ-026 While rst is high: state IDLE, cnt = 0, bit index = 0, shift register = 0, synchronizer flops = 1.
REQ-027 While rst is high: out_data = 0, and out_valid, parity_err, frame_err, overrun and busy are all 0.
REQ-028 Reset asserted mid-frame shall discard the partial frame and any pending output.

Configuration
REQ-029 Macro UART_RX_PARITY_EN: when defined, PARITY state and parity_err are active as specified.
REQ-030 When UART_RX_PARITY_EN is undefined, DATA goes directly to STOP, the frame is 10 bits long, and parity_err is tied to 0.

Structure
REQ-031 Package uart_pkg shall hold the state enum type, UART_DATA_W = 8 and UART_CNT_W = 10.
REQ-032 The synchronizer shall be a sub-module uart_sync (parameter SYNC_STAGES, reset value 1).

Verification (clks_per_bit=9, P=10, out_ready=1 unless stated, parity enabled)
REQ-033 Frame 0xA5, parity 0, stop 1 -> out_data=0xA5, parity_err=0, frame_err=0, out_valid pulses for 1 cycle.
REQ-034 Frame 0x01 with parity bit 0 -> out_data=0x01, parity_err=1.
REQ-035 Frame 0x3C with stop bit 0 -> out_data=0x3C, frame_err=1; the following frame 0x55 is received correctly.
REQ-036 rx_line low for 3 cycles, then high -> returns to IDLE, no out_valid, busy high for at most 5+SYNC_STAGES cycles.
REQ-037 out_ready=0; frames 0x11 then 0x22 back-to-back -> after the 2nd frame, out_data=0x22 and overrun=1; out_ready=1 for one cycle -> out_valid=0.
REQ-038 rst pulsed during data bit 4 of 0x0F, then frame 0xF0 -> no output for 0x0F, out_data=0xF0, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART frame receiver.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_CNT_W  = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_RX_PARITY_EN to receive and check the parity bit; otherwise frames are 10 bits.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_line,
    input  logic [UART_CNT_W-1:0] clks_per_bit,
    output logic [UART_DATA_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy,
    output logic [2:0]            fsm_state
);

    // Handshake: a byte transfers in any cycle where out_valid && out_ready are both
    // high at the rising edge; out_valid and the flags hold steady until then.

    state_t                 state, state_nxt;
    logic [UART_CNT_W-1:0]  cnt, cnt_nxt;
    logic [2:0]             bit_idx, bit_idx_nxt;
    logic [UART_DATA_W-1:0] shift, shift_nxt;
    logic                   rx_s, rx_prev;
    logic                   bit_done, half_done, stop_sample;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit, par_bit_nxt;
`endif

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_line),
        .q   (rx_s)
    );

    // >= rather than == so a mid-frame clks_per_bit change can never strand the counter.
    assign bit_done  = (cnt >= clks_per_bit);
    assign half_done = (cnt >= (clks_per_bit >> 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rx_prev <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            rx_prev <= rx_s;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_bit_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
`endif
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_done) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_s, shift[UART_DATA_W-1:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_nxt     = '0;
                    par_bit_nxt = rx_s;
                    state_nxt   = STOP;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    cnt_nxt     = '0;
                    stop_sample = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // A stop sample wins over acceptance, so a byte arriving as the old one leaves is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (stop_sample) begin
            out_data  <= shift;
            out_valid <= 1'b1;
            frame_err <= ~rx_s;
            overrun   <= out_valid && !out_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= (par_bit != ^shift);
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at clks_per_bit=9 (10 clocks per bit).
module tb_uart_frame_rx;

    localparam int SYNC = 2;
    localparam int P    = 10;

`ifdef UART_RX_PARITY_EN
    localparam logic PE_BAD = 1'b1;
`else
    localparam logic PE_BAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_line;
    logic [9:0] clks_per_bit;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_bad    = 0;
    int n_got    = 0;
    int n_extra  = 0;
    int vcount   = 0;

    // {overrun, frame_err, parity_err, out_data}
    logic [10:0] exp_q[$];

    uart_frame_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_line      (rx_line),
        .clks_per_bit (clks_per_bit),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        tick(P);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) rx_line = 1'b1;
`endif
        send_bit(stp);
        rx_line = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) vcount++;
        if (!rst && out_valid && out_ready) begin
            n_got++;
            if (exp_q.size() > 0) begin
                check("rx_byte", {overrun, frame_err, parity_err, out_data}, exp_q.pop_front());
            end else begin
                n_extra++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, v0, bc;
        rst = 1'b1;
        rx_line = 1'b1;
        out_ready = 1'b1;
        clks_per_bit = 10'd9;
        tick(3);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_state", fsm_state, 0);
        rst = 1'b0;
        tick(5);

        // clean frame 0xA5
        g0 = n_got; v0 = vcount;
        exp_q.push_back({3'b000, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b1);
        tick(5);
        check("a5_count", n_got - g0, 1);
        check("a5_valid_pulse", vcount - v0, 1);
        check("a5_valid_low", out_valid, 0);

        // bad parity on 0x01
        g0 = n_got;
        exp_q.push_back({1'b0, 1'b0, PE_BAD, 8'h01});
        send_frame(8'h01, 1'b0, 1'b1);
        tick(5);
        check("p01_count", n_got - g0, 1);

        // framing error on 0x3C, then clean 0x55
        g0 = n_got;
        exp_q.push_back({3'b010, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(15);
        exp_q.push_back({3'b000, 8'h55});
        send_frame(8'h55, 1'b0, 1'b1);
        tick(5);
        check("fe_count", n_got - g0, 2);

        // 3-cycle glitch is rejected
        g0 = n_got; v0 = vcount; bc = 0;
        rx_line = 1'b0;
        tick(3);
        rx_line = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy) bc++;
            tick(1);
        end
        check("glitch_busy_bound", (bc <= 5 + SYNC), 1);
        check("glitch_busy_seen", (bc > 0), 1);
        check("glitch_no_valid", vcount - v0, 0);
        check("glitch_idle", busy, 0);

        // overrun with consumer stalled, back-to-back frames
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        tick(3);
        check("ovr_valid", out_valid, 1);
        check("ovr_data", out_data, 8'h22);
        check("ovr_flag", overrun, 1);
        check("ovr_frame_err", frame_err, 0);
        g0 = n_got;
        exp_q.push_back({3'b100, 8'h22});
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("ovr_valid_drop", out_valid, 0);
        check("ovr_accept_count", n_got - g0, 1);
        out_ready = 1'b1;
        tick(5);

        // reset during data bit 4 of 0x0F, then 0xF0
        g0 = n_got;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_line = 1'b0;
        tick(5);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        rx_line = 1'b1;
        tick(2);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        rst = 1'b0;
        tick(20);
        check("mid_no_partial", n_got - g0, 0);
        exp_q.push_back({3'b000, 8'hF0});
        send_frame(8'hF0, 1'b0, 1'b1);
        tick(5);
        check("f0_count", n_got - g0, 1);
        check("f0_data", out_data, 8'hF0);

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check("exp_q_drained", exp_q.size(), 0);
        check("extra_outputs", n_extra, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
